// File: rtl/motor_duty_ramp.sv
// Per-motor PWM duty slew controller with dead-time direction reversal.
// Duty and enables only move on the period boundary (internal counter at 3FF).
module motor_duty_ramp #(
  parameter int STEP         = 8,
  parameter int DEAD_PERIODS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] tgt,
  input  logic        tgt_vld,
  output logic [9:0]  duty,
  output logic        fwd,
  output logic        rev,
  output logic        period_start,
  output logic        busy
);

  typedef enum logic [1:0] {RUN, DECEL, DEAD} state_t;

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [3:0]  DEAD4  = 4'(DEAD_PERIODS);

  state_t      state_reg, state_next;
  logic [9:0]  cnt_reg;
  logic [10:0] tgt_reg;
  logic [9:0]  duty_reg, duty_next;
  logic        dir_reg, dir_next;
  logic [3:0]  dead_reg, dead_next;
  logic        fwd_reg, fwd_next;
  logic        rev_reg, rev_next;

  logic        boundary;
  logic [10:0] abs_tgt;
  logic [9:0]  mag;
  logic        need_rev;
  logic [10:0] duty11, mag11, up_sum, down_diff;
  logic [9:0]  toward_val, decel_val;

  assign boundary = (cnt_reg == 10'h3FF);

  // |tgt| needs 11 bits for -1024, which then saturates to 1023.
  assign abs_tgt  = tgt_reg[10] ? (~tgt_reg + 11'd1) : tgt_reg;
  assign mag      = abs_tgt[10] ? 10'h3FF : abs_tgt[9:0];
  assign need_rev = (mag != 10'd0) && (tgt_reg[10] != dir_reg);

  assign duty11    = {1'b0, duty_reg};
  assign mag11     = {1'b0, mag};
  assign up_sum    = duty11 + STEP11;
  assign down_diff = duty11 - STEP11;

  always_comb begin
    toward_val = mag;
    if (duty11 < mag11) begin
      if (up_sum <= mag11) toward_val = up_sum[9:0];
    end else if (duty11 >= mag11 + STEP11) begin
      toward_val = down_diff[9:0];
    end
  end

  assign decel_val = (duty11 > STEP11) ? down_diff[9:0] : 10'd0;

  // State register and all other registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= 10'h3FF;
      tgt_reg   <= 11'd0;
      duty_reg  <= 10'd0;
      dir_reg   <= 1'b0;
      dead_reg  <= 4'd0;
      fwd_reg   <= 1'b1;
      rev_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_reg + 10'd1;
      if (tgt_vld) tgt_reg <= tgt;
      duty_reg  <= duty_next;
      dir_reg   <= dir_next;
      dead_reg  <= dead_next;
      fwd_reg   <= fwd_next;
      rev_reg   <= rev_next;
    end
  end

  // Next state. A reversal whose decel step already lands on 0 goes straight to DEAD.
  always_comb begin
    state_next = state_reg;
    dead_next  = dead_reg;
    dir_next   = dir_reg;
    if (boundary) begin
      case (state_reg)
        DEAD: begin
          if (dead_reg == 4'd1) begin
            dir_next   = ~dir_reg;
            state_next = RUN;
          end else begin
            dead_next = dead_reg - 4'd1;
          end
        end
        default: begin
          if (need_rev) begin
            if (decel_val == 10'd0) begin
              state_next = DEAD;
              dead_next  = DEAD4;
            end else begin
              state_next = DECEL;
            end
          end else begin
            state_next = RUN;
          end
        end
      endcase
    end
  end

  // Registered outputs: duty and H-bridge enables.
  always_comb begin
    duty_next = duty_reg;
    fwd_next  = fwd_reg;
    rev_next  = rev_reg;
    if (boundary) begin
      if (state_next == DEAD) begin
        duty_next = 10'd0;
        fwd_next  = 1'b0;
        rev_next  = 1'b0;
      end else begin
        fwd_next  = ~dir_next;
        rev_next  = dir_next;
        if (state_reg == DEAD) duty_next = 10'd0;
        else if (need_rev)     duty_next = decel_val;
        else                   duty_next = toward_val;
      end
    end
  end

  assign duty         = duty_reg;
  assign fwd          = fwd_reg;
  assign rev          = rev_reg;
  assign period_start = boundary;
  assign busy         = !((state_reg == RUN) && (duty_reg == mag));

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Bench for motor_duty_ramp: directed scenarios against fixed expectations,
// then random target strobes against a per-period behavioural model.
module tb_motor_duty_ramp;

  logic        clk, rst_n, tgt_vld;
  logic [10:0] tgt;
  logic [9:0]  duty, d2_duty;
  logic        fwd, rev, period_start, busy;
  logic        d2_fwd, d2_rev, d2_period_start, d2_busy;

  int checks = 0;
  int errors = 0;

  motor_duty_ramp #(.STEP(8), .DEAD_PERIODS(2)) dut (
    .clk(clk), .rst_n(rst_n), .tgt(tgt), .tgt_vld(tgt_vld),
    .duty(duty), .fwd(fwd), .rev(rev), .period_start(period_start), .busy(busy)
  );

  // Coarse step so saturation is reachable within a few periods.
  motor_duty_ramp #(.STEP(340), .DEAD_PERIODS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tgt(tgt), .tgt_vld(tgt_vld),
    .duty(d2_duty), .fwd(d2_fwd), .rev(d2_rev), .period_start(d2_period_start), .busy(d2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one update per PWM period. mode 0=run, 1=slowing for reversal, 2=dead.
  typedef struct packed {
    int duty;
    int dir;
    int mode;
    int dead;
  } mst_t;

  mst_t        m;
  logic [10:0] m_tgt;
  logic [9:0]  tb_cnt;

  function automatic int mag_of(logic [10:0] t);
    int v;
    v = $signed(t);
    if (v < 0) v = -v;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  function automatic mst_t model_next(mst_t s, logic [10:0] t);
    mst_t n;
    int   mg;
    int   sgn;
    n   = s;
    mg  = mag_of(t);
    sgn = t[10] ? 1 : 0;
    if (s.mode == 2) begin
      n.duty = 0;
      if (s.dead == 1) begin
        n.dir  = 1 - s.dir;
        n.mode = 0;
      end else begin
        n.dead = s.dead - 1;
      end
    end else if (mg != 0 && sgn != s.dir) begin
      n.duty = (s.duty > 8) ? s.duty - 8 : 0;
      if (n.duty == 0) begin
        n.mode = 2;
        n.dead = 2;
      end else begin
        n.mode = 1;
      end
    end else begin
      n.mode = 0;
      if (s.duty < mg) n.duty = (s.duty + 8 > mg) ? mg : s.duty + 8;
      else             n.duty = (s.duty - 8 < mg) ? mg : s.duty - 8;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m      <= '{duty: 0, dir: 0, mode: 0, dead: 0};
      m_tgt  <= 11'd0;
      tb_cnt <= 10'h3FF;
    end else begin
      tb_cnt <= tb_cnt + 10'd1;
      if (tgt_vld) m_tgt <= tgt;
      if (tb_cnt == 10'h3FF) m <= model_next(m, m_tgt);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tgt_vld = 1'b0; tgt = 11'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance to the negedge just after the next boundary edge.
  task automatic adv();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != 10'h000 && n < 1100);
    if (tb_cnt != 10'h000) begin
      errors++;
      $display("FAIL adv_timeout cnt=%0h", tb_cnt);
    end
  endtask

  task automatic strobe(input int v);
    tgt = v[10:0]; tgt_vld = 1'b1;
    @(negedge clk);
    tgt_vld = 1'b0;
    $display("strobe tgt=%0d", v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tgt_vld = 1'b0; tgt = 11'd0;
    repeat (3) @(negedge clk);
    checks++; if (duty !== 10'd0)        begin errors++; $display("FAIL reset_duty got %0d exp 0", duty); end
    checks++; if (fwd !== 1'b1)          begin errors++; $display("FAIL reset_fwd got %0b exp 1", fwd); end
    checks++; if (rev !== 1'b0)          begin errors++; $display("FAIL reset_rev got %0b exp 0", rev); end
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL reset_pstart got %0b exp 1", period_start); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    rst_n = 1'b1;
    $display("reset done");
  endtask

  task automatic test_ramp_up();
    adv();
    strobe(40);
    for (int i = 0; i < 5; i++) begin
      adv();
      $display("ramp b=%0d duty=%0d fwd=%0b busy=%0b", i + 1, duty, fwd, busy);
      checks++; if (duty !== 10'(8 * (i + 1))) begin errors++; $display("FAIL ramp_duty b=%0d got %0d exp %0d", i + 1, duty, 8 * (i + 1)); end
      checks++; if (fwd !== 1'b1 || rev !== 1'b0) begin errors++; $display("FAIL ramp_en b=%0d got %0b%0b exp 10", i + 1, fwd, rev); end
      checks++; if (busy !== (i < 4)) begin errors++; $display("FAIL ramp_busy b=%0d got %0b exp %0b", i + 1, busy, i < 4); end
    end
  endtask

  task automatic test_reversal();
    int ed [10] = '{32, 24, 16, 8, 0, 0, 0, 8, 16, 16};
    int ef [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int er [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int eb [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    strobe(-16);
    for (int i = 0; i < 10; i++) begin
      adv();
      $display("rev b=%0d duty=%0d fwd=%0b rev=%0b busy=%0b", i, duty, fwd, rev, busy);
      checks++; if (duty !== 10'(ed[i])) begin errors++; $display("FAIL rev_duty b=%0d got %0d exp %0d", i, duty, ed[i]); end
      checks++; if (fwd !== 1'(ef[i]) || rev !== 1'(er[i])) begin errors++; $display("FAIL rev_en b=%0d got %0b%0b exp %0d%0d", i, fwd, rev, ef[i], er[i]); end
      checks++; if (busy !== 1'(eb[i])) begin errors++; $display("FAIL rev_busy b=%0d got %0b exp %0d", i, busy, eb[i]); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    adv();
    strobe(40);
    repeat (5) adv();
    strobe(-16);
    adv();
    checks++; if (duty !== 10'd32 || fwd !== 1'b1) begin errors++; $display("FAIL abort_decel got duty=%0d fwd=%0b exp 32 1", duty, fwd); end
    strobe(24);
    adv();
    $display("abort duty=%0d fwd=%0b rev=%0b busy=%0b", duty, fwd, rev, busy);
    checks++; if (duty !== 10'd24) begin errors++; $display("FAIL abort_duty got %0d exp 24", duty); end
    checks++; if (fwd !== 1'b1 || rev !== 1'b0) begin errors++; $display("FAIL abort_en got %0b%0b exp 10", fwd, rev); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
  endtask

  task automatic test_saturation();
    int ed [6] = '{0, 0, 0, 340, 680, 1020};
    int er [6] = '{0, 0, 1, 1, 1, 1};
    do_reset();
    adv();
    strobe(-1020);
    for (int i = 0; i < 6; i++) begin
      adv();
      $display("sat b=%0d duty=%0d fwd=%0b rev=%0b", i, d2_duty, d2_fwd, d2_rev);
      checks++; if (d2_duty !== 10'(ed[i])) begin errors++; $display("FAIL sat_duty b=%0d got %0d exp %0d", i, d2_duty, ed[i]); end
      checks++; if (d2_fwd !== 1'b0 || d2_rev !== 1'(er[i])) begin errors++; $display("FAIL sat_en b=%0d got %0b%0b exp 0%0d", i, d2_fwd, d2_rev, er[i]); end
    end
    strobe(-1024);
    for (int i = 0; i < 2; i++) begin
      adv();
      $display("sat_clamp duty=%0d busy=%0b", d2_duty, d2_busy);
      checks++; if (d2_duty !== 10'd1023) begin errors++; $display("FAIL sat_clamp got %0d exp 1023", d2_duty); end
      checks++; if (d2_busy !== 1'b0) begin errors++; $display("FAIL sat_busy got %0b exp 0", d2_busy); end
    end
    do_reset();
    adv();
    strobe(3);
    adv();
    $display("small duty=%0d busy=%0b", duty, busy);
    checks++; if (duty !== 10'd3 || busy !== 1'b0) begin errors++; $display("FAIL small_step got duty=%0d busy=%0b exp 3 0", duty, busy); end
  endtask

  task automatic test_boundary_strobe();
    int n;
    do_reset();
    adv();
    n = 0;
    while (tb_cnt != 10'h3FF && n < 1100) begin
      @(negedge clk);
      n++;
    end
    tgt = 11'd100; tgt_vld = 1'b1;
    @(negedge clk);
    tgt_vld = 1'b0;
    $display("bstrobe edge duty=%0d busy=%0b", duty, busy);
    checks++; if (duty !== 10'd0) begin errors++; $display("FAIL bstrobe_hold got %0d exp 0", duty); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bstrobe_busy got %0b exp 1", busy); end
    adv();
    $display("bstrobe next duty=%0d", duty);
    checks++; if (duty !== 10'd8) begin errors++; $display("FAIL bstrobe_next got %0d exp 8", duty); end
  endtask

  task automatic test_reset_mid_dead();
    do_reset();
    adv();
    strobe(-16);
    adv();
    checks++; if (fwd !== 1'b0 || rev !== 1'b0) begin errors++; $display("FAIL dead_en got %0b%0b exp 00", fwd, rev); end
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("middead reset duty=%0d fwd=%0b rev=%0b pstart=%0b", duty, fwd, rev, period_start);
    checks++; if (duty !== 10'd0 || fwd !== 1'b1 || rev !== 1'b0) begin errors++; $display("FAIL middead_out got %0d %0b%0b exp 0 10", duty, fwd, rev); end
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL middead_pstart got %0b exp 1", period_start); end
    repeat (3) @(negedge clk);
    checks++; if (period_start !== 1'b1 || fwd !== 1'b1) begin errors++; $display("FAIL middead_held got ps=%0b fwd=%0b exp 1 1", period_start, fwd); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int b, v, mg;
    do_reset();
    b = 0;
    for (int i = 0; i < 25 * 1024; i++) begin
      @(negedge clk);
      if (tb_cnt == 10'h000) begin
        b++;
        mg = mag_of(m_tgt);
        $display("rnd b=%0d tgt=%0d duty=%0d fwd=%0b rev=%0b busy=%0b", b, $signed(m_tgt), duty, fwd, rev, busy);
        checks++; if (duty !== 10'(m.duty)) begin errors++; $display("FAIL rnd_duty b=%0d got %0d exp %0d", b, duty, m.duty); end
        checks++; if (fwd !== (m.mode != 2 && m.dir == 0)) begin errors++; $display("FAIL rnd_fwd b=%0d got %0b", b, fwd); end
        checks++; if (rev !== (m.mode != 2 && m.dir == 1)) begin errors++; $display("FAIL rnd_rev b=%0d got %0b", b, rev); end
        checks++; if (busy !== !(m.mode == 0 && m.duty == mg)) begin errors++; $display("FAIL rnd_busy b=%0d got %0b", b, busy); end
      end
      checks++;
      if (period_start !== (tb_cnt == 10'h3FF)) begin errors++; $display("FAIL rnd_pstart cnt=%0h got %0b", tb_cnt, period_start); end
      tgt_vld = 1'b0;
      if ($urandom_range(0, 399) == 0 || (tb_cnt == 10'h3FF && $urandom_range(0, 2) == 0)) begin
        v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 60));
        if ($urandom_range(0, 1) == 1) v = -v;
        if ($urandom_range(0, 15) == 0) v = -1024;
        tgt = v[10:0];
        tgt_vld = 1'b1;
      end
    end
    tgt_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_abort();
    test_saturation();
    test_boundary_strobe();
    test_reset_mid_dead();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_duty_ramp.md
# motor_duty_ramp

Per-motor PWM duty controller that sits between the line-following steering logic and the PWM generator. It accepts a signed speed target and owns an internal 10-bit period counter that runs in lock-step with the PWM generator's counter. Once per PWM period it steps the 10-bit duty toward the target magnitude at a fixed slew rate. On a direction reversal it ramps to zero, holds both direction enables low for a dead time, flips direction, then ramps up.

## Interface
- STEP, 8: duty change per PWM period; legal 1..1023
- DEAD_PERIODS, 2: full PWM periods with both enables low during a reversal; legal 1..15
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tgt  input  11  signed two's-complement target speed; magnitude is duty, sign is direction (negative = reverse)
- tgt_vld  input  1  single-cycle strobe; `tgt` is captured on the clk edge where this is high
- duty  output  10  duty to the PWM generator; registered
- fwd  output  1  forward H-bridge enable; registered
- rev  output  1  reverse H-bridge enable; registered
- period_start  output  1  high for the one cycle in which the internal counter is 10'h3FF
- busy  output  1  high unless state is RUN and duty equals the latched target magnitude

## Operation
- Period counter
  - 10 bits; resets to 10'h3FF and increments every cycle, wrapping.
  - The boundary is the cycle where the counter is 10'h3FF. This matches the PWM generator's set point, so a new duty takes effect from count 0.
- Target latch
  - Captures `tgt` on `tgt_vld`; a later strobe overwrites an earlier one. Reset value is 0.
  - Magnitude is `|tgt|`, saturated to 1023, so −1024 gives 1023.
  - Sign is negative iff `tgt[10]`.
- Reversal rule: a reversal is needed when the latched magnitude is nonzero and its sign differs from `dir`. A target of 0 never triggers a reversal.
- State machine (states RUN, DECEL, DEAD); all updates happen only at boundaries:
  - **RUN**
    - If a reversal is needed, go to DECEL in the same boundary and apply a decel step.
    - Otherwise move `duty` toward the magnitude by STEP without overshoot: `duty` = min(duty+STEP, mag) or max(duty−STEP, mag).
  - **DECEL**
    - `duty` = max(duty−STEP, 0).
    - If the latched sign now matches `dir` (or the magnitude is 0), return to RUN, and this boundary's step follows RUN rules instead.
    - When `duty` reaches 0: go to DEAD, set the dead counter to DEAD_PERIODS, and deassert `fwd`/`rev` on that same edge.
  - **DEAD**
    - `duty` is held at 0 and `fwd` = `rev` = 0.
    - At each boundary: if the dead counter is 1, toggle `dir`, go to RUN, and assert the new enable; otherwise decrement the counter.
    - Target changes during DEAD are latched but are acted on only after returning to RUN.
- Enables outside DEAD: `fwd` = !dir and `rev` = dir, so exactly one is high. `fwd` and `rev` are never high together.
- Arithmetic is 11-bit internally, so duty+STEP cannot wrap past 1023 before the clamp.

## Timing
- Reset values: duty=0, fwd=1, rev=0, dir=forward, state=RUN, counter=10'h3FF, target=0, busy=0, period_start=1 (the counter is at 3FF).
- The first boundary is the first clk edge after rst_n deasserts. Boundaries then recur every 1024 cycles.
- Target-to-duty latency: a `tgt_vld` at any cycle, including the boundary cycle itself, is used at the next boundary edge strictly after capture. A strobe coinciding with the boundary edge is therefore used one period later.
- Outputs change only on boundary edges; `busy` is combinational from registered state.
- Asserting reset mid-ramp or mid-DEAD returns everything immediately to the reset values. No dead time is enforced across reset; the board-level enable default covers that case.

## Test plan
- **Ramp up.** Reset, then `tgt`=+40 before the first boundary, STEP=8 → at boundaries 1..5 `duty` = 8, 16, 24, 32, 40 with `fwd`=1. `busy` falls at boundary 5.
- **Reversal.** From +40, `tgt`=−16 → `duty` 32, 24, 16, 8, 0. At the 0 boundary `fwd`=`rev`=0. They stay 0 for 2 more boundaries; at the second `rev`=1. At the following boundaries `duty` = 8, 16, then holds 16 and `busy`=0.
- **Abort during DECEL.** From +40, `tgt`=−16, then `tgt`=+24 after the duty-32 boundary → next boundary gives `duty`=24 in RUN. `fwd` never drops.
- **Saturation / no overshoot.** `tgt`=−1024 from reverse at duty 1020, STEP=8 → `duty`=1023 in one step and stays there. `tgt`=+3 with duty 0 → `duty`=3.
- **Boundary-coincident strobe.** `tgt_vld` on the cycle where the counter is 3FF → `duty` unchanged at that edge and updated 1024 cycles later.
- **Reset mid-DEAD.** Assert rst_n=0 during DEAD → `duty`=0, `fwd`=1, `rev`=0, `period_start`=1 while reset is held.
